// File: rtl/alu_issue_fsm.sv
// ---------------------------------------------------------------------------
// alu_issue_fsm
//   Instruction-side driver for an external combinational 16-bit ALU.
//   Sequence per instruction: FETCH -> READ -> EXEC -> WB -> FETCH.
//   Accepts one 16-bit word per valid/ready handshake and reads Rdest/Rsrc
//   from the register file. It drives the ALU operands and opcode, captures
//   the result and flags, writes the result back, and maintains the 5-bit
//   PSR {N,Z,F,L,C}.
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   instr_valid/instr        instruction word offer
//   instr_ready              high in FETCH, from the first edge after reset
//   rf_raddr_a/rf_raddr_b    Rdest / Rsrc read addresses (driven in READ)
//   rf_rdata_a/rf_rdata_b    read data, valid one cycle after address
//   rf_we/rf_waddr/rf_wdata  writeback port (driven in WB)
//   alu_a/alu_b/alu_op       ALU inputs (non-zero only in EXEC)
//   alu_out/alu_flags        ALU result and flags {N,Z,F,L,C}
//   psr                      processor status register
//   done                     one-cycle pulse per retired legal instruction
//   illegal                  one-cycle pulse per undecodable instruction
// ---------------------------------------------------------------------------
module alu_issue_fsm #(
  parameter int REG_AW = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [REG_AW-1:0] rf_raddr_a,
  output logic [REG_AW-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [7:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [4:0]        alu_flags,
  output logic [4:0]        psr,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [1:0] {S_FETCH, S_READ, S_EXEC, S_WB} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_rdy_en;   // keeps instr_ready low until the first edge after reset
  logic [15:0]         r_instr;
  logic [DATA_W-1:0]   r_result;
  logic [4:0]          r_flags;
  logic [4:0]          r_psr;

  logic [3:0]          w_opc;
  logic [3:0]          w_ext;
  logic [7:0]          w_op;
  logic                w_legal;
  logic                w_is_imm;
  logic                w_swap;      // CMP/MOV/NOT take Rsrc/imm as A and Rdest as B
  logic                w_wb;
  logic                w_psr_upd;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_src;
  logic                w_accept;

  assign w_opc    = r_instr[15:12];
  assign w_ext    = r_instr[7:4];
  assign w_accept = instr_valid & instr_ready;
  assign psr      = r_psr;

  // ---------------- state register ----------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    // NOTE: a default assignment at the top of every always_comb guarantees
    // no path leaves a signal unassigned, so no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_FETCH: if (w_accept) w_next_state = S_READ;
      S_READ:  w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_WB;
      S_WB:    w_next_state = S_FETCH;
      default: w_next_state = S_FETCH;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en <= 1'b0;
      r_instr  <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_psr    <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (r_state == S_FETCH && w_accept) r_instr <= instr;
      if (r_state == S_EXEC) begin
        r_result <= alu_out;
        r_flags  <= alu_flags;
      end
      if (r_state == S_WB && w_legal && w_psr_upd) r_psr <= r_flags;
    end
  end

  // ---------------- decode of the latched word ----------------
  always_comb begin
    w_op      = '0;
    w_legal   = 1'b0;
    w_is_imm  = 1'b0;
    w_swap    = 1'b0;
    w_wb      = 1'b0;
    w_psr_upd = 1'b0;
    w_imm     = '0;
    case (w_opc)
      4'h0: begin
        w_op = {w_opc, w_ext};
        case (w_ext)
          4'h1, 4'h2, 4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD: begin
            w_legal   = 1'b1;
            w_wb      = (w_ext != 4'hB);
            w_swap    = (w_ext == 4'h7) || (w_ext == 4'hB) || (w_ext == 4'hD);
            w_psr_upd = (w_ext == 4'h5) || (w_ext == 4'h9) || (w_ext == 4'hB);
          end
          default: ;
        endcase
      end
      4'h8: begin
        w_op = {w_opc, w_ext};
        if (w_ext == 4'h4 || w_ext == 4'h6) begin
          w_legal = 1'b1;
          w_wb    = 1'b1;
        end
      end
      4'h1, 4'h2, 4'h3: begin
        // logical immediates are zero-extended
        w_op     = {4'b0000, w_opc};
        w_legal  = 1'b1;
        w_is_imm = 1'b1;
        w_wb     = 1'b1;
        w_imm    = {{(DATA_W-8){1'b0}}, r_instr[7:0]};
      end
      4'h5, 4'h9, 4'hB, 4'hD: begin
        // arithmetic / compare / move immediates are sign-extended
        w_op      = {4'b0000, w_opc};
        w_legal   = 1'b1;
        w_is_imm  = 1'b1;
        w_wb      = (w_opc != 4'hB);
        w_swap    = (w_opc == 4'hB) || (w_opc == 4'hD);
        w_psr_upd = (w_opc != 4'hD);
        w_imm     = {{(DATA_W-8){r_instr[7]}}, r_instr[7:0]};
      end
      default: ;
    endcase
  end

  assign w_src = w_is_imm ? w_imm : rf_rdata_b;

  // ---------------- outputs ----------------
  always_comb begin
    instr_ready = 1'b0;
    rf_raddr_a  = '0;
    rf_raddr_b  = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      S_FETCH: instr_ready = r_rdy_en;
      S_READ: begin
        rf_raddr_a = REG_AW'(r_instr[11:8]);
        rf_raddr_b = REG_AW'(r_instr[3:0]);
      end
      S_EXEC: begin
        if (w_legal) begin
          alu_op = w_op;
          alu_a  = w_swap ? w_src : rf_rdata_a;
          alu_b  = w_swap ? rf_rdata_a : w_src;
        end
      end
      S_WB: begin
        rf_we    = w_legal & w_wb;
        rf_waddr = REG_AW'(r_instr[11:8]);
        rf_wdata = r_result;
        done     = w_legal;
        illegal  = ~w_legal;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_issue_fsm.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_fsm
//   Directed bench for alu_issue_fsm. Provides a 16-entry register file with
//   a registered read port and a small combinational ALU model. Expected
//   values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_issue_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [7:0]  alu_op;
  logic [4:0]  alu_flags, psr;
  logic        done, illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue_fsm #(.REG_AW(4), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .psr(psr), .done(done), .illegal(illegal)
  );

  // ---------------- register file model ----------------
  logic [15:0] rf_mem [16];
  logic        tb_we;
  logic [3:0]  tb_waddr;
  logic [15:0] tb_wdata;

  always @(posedge clk) begin
    rf_rdata_a <= rf_mem[rf_raddr_a];
    rf_rdata_b <= rf_mem[rf_raddr_b];
    if (rf_we)      rf_mem[rf_waddr] <= rf_wdata;
    else if (tb_we) rf_mem[tb_waddr] <= tb_wdata;
  end

  // ---------------- ALU model, flags {N,Z,F,L,C} ----------------
  logic [16:0] sum;
  always_comb begin
    alu_out   = '0;
    alu_flags = '0;
    sum       = '0;
    case (alu_op)
      8'h01: alu_out = alu_a & alu_b;
      8'h02: alu_out = alu_a | alu_b;
      8'h03: alu_out = alu_a ^ alu_b;
      8'h05: begin
        sum       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out   = sum[15:0];
        alu_flags = {sum[15], sum[15:0] == 16'h0,
                     (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]), 1'b0, sum[16]};
      end
      8'h07: alu_out = ~alu_a;
      8'h09: begin
        sum       = {1'b0, alu_a} - {1'b0, alu_b};
        alu_out   = sum[15:0];
        alu_flags = {sum[15], sum[15:0] == 16'h0,
                     (alu_a[15] != alu_b[15]) && (sum[15] != alu_a[15]), 1'b0, alu_a < alu_b};
      end
      8'h0B: alu_flags = {$signed(alu_a) > $signed(alu_b), alu_a == alu_b, 1'b0,
                          alu_a > alu_b, 1'b0};
      8'h0D: alu_out = alu_a;
      8'h84, 8'h86: alu_out = alu_a << alu_b[3:0];
      default: ;
    endcase
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    tick();
    tb_we = 1'b0;
  endtask

  logic [7:0]  cap_op;
  logic [15:0] cap_a, cap_b, cap_wdata;
  logic        cap_we, cap_done, cap_ill, cap_done_exec;

  // Issue one word from FETCH and capture EXEC/WB observations; returns in FETCH.
  task automatic run_instr(input logic [15:0] w);
    check("ready_in_fetch", instr_ready, 1);
    instr_valid = 1'b1; instr = w;
    tick();
    instr_valid = 1'b0; instr = '0;
    check("ready_low_read", instr_ready, 0);
    tick();
    cap_op = alu_op; cap_a = alu_a; cap_b = alu_b; cap_done_exec = done;
    tick();
    cap_we = rf_we; cap_done = done; cap_ill = illegal; cap_wdata = rf_wdata;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1; instr_valid = 1'b0; instr = '0;
    tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 16; i++) preload(4'(i), 16'h0000);
    preload(4'd1, 16'h0003);
    preload(4'd2, 16'h0004);
    preload(4'd3, 16'h0005);
    preload(4'd4, 16'hFFFF);
    preload(4'd5, 16'hFFFF);

    // reset release with instr_valid held high: ADD R1,R2
    instr_valid = 1'b1; instr = 16'h0152;
    tick();
    check("rst_ready", instr_ready, 0);
    check("rst_psr", psr, 0);
    check("rst_we", rf_we, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_alu_op", alu_op, 0);
    rst_n = 1'b1;
    #1 check("ready_before_first_edge", instr_ready, 0);
    tick();
    check("ready_first_edge", instr_ready, 1);
    tick();                               // handshake accepted here
    instr_valid = 1'b0; instr = '0;
    check("read_ready", instr_ready, 0);
    check("read_addr_a", rf_raddr_a, 1);
    check("read_addr_b", rf_raddr_b, 2);
    check("read_done", done, 0);
    tick();
    check("add_op", alu_op, 8'h05);
    check("add_a", alu_a, 16'h0003);
    check("add_b", alu_b, 16'h0004);
    check("add_done_exec", done, 0);
    tick();
    check("add_done_wb", done, 1);
    check("add_we", rf_we, 1);
    check("add_waddr", rf_waddr, 1);
    check("add_wdata", rf_wdata, 16'h0007);
    tick();
    check("add_done_after", done, 0);
    check("add_r1", rf_mem[1], 16'h0007);
    check("add_psr", psr, 5'b00000);

    // CMP R3,R4: swapped operands, no write, L set
    run_instr(16'h03B4);
    check("cmp_op", cap_op, 8'h0B);
    check("cmp_a", cap_a, 16'hFFFF);
    check("cmp_b", cap_b, 16'h0005);
    check("cmp_we", cap_we, 0);
    check("cmp_done", cap_done, 1);
    check("cmp_r3", rf_mem[3], 16'h0005);
    check("cmp_psr", psr, 5'b00010);

    // ANDI R5,#0x80: zero-extended, psr unchanged
    run_instr(16'h1580);
    check("andi_op", cap_op, 8'h01);
    check("andi_a", cap_a, 16'hFFFF);
    check("andi_b", cap_b, 16'h0080);
    check("andi_r5", rf_mem[5], 16'h0080);
    check("andi_psr", psr, 5'b00010);

    // ADDI R5,#0x80: sign-extended, 0x0080+0xFF80 -> 0 with carry
    run_instr(16'h5580);
    check("addi_op", cap_op, 8'h05);
    check("addi_b", cap_b, 16'hFF80);
    check("addi_r5", rf_mem[5], 16'h0000);
    check("addi_psr", psr, 5'b01001);

    // illegal ext in register group
    run_instr(16'h0F0F);
    check("ill_op", cap_op, 0);
    check("ill_we", cap_we, 0);
    check("ill_done", cap_done, 0);
    check("ill_pulse", cap_ill, 1);
    check("ill_psr", psr, 5'b01001);
    check("ill_after", illegal, 0);

    // illegal primary opcode
    run_instr(16'h4123);
    check("ill2_pulse", cap_ill, 1);
    check("ill2_we", cap_we, 0);

    // MOV R6,R1 after illegal: swap, R6 <- 7
    run_instr(16'h06D1);
    check("mov_op", cap_op, 8'h0D);
    check("mov_a", cap_a, 16'h0007);
    check("mov_b", cap_b, 16'h0000);
    check("mov_r6", rf_mem[6], 16'h0007);
    check("mov_done", cap_done, 1);
    check("mov_done_exec", cap_done_exec, 0);

    // XOR R1,R1 then ADD R2,R1: second sees the new R1
    run_instr(16'h0131);
    check("xor_r1", rf_mem[1], 16'h0000);
    run_instr(16'h0251);
    check("add2_b", cap_b, 16'h0000);
    check("add2_r2", rf_mem[2], 16'h0004);
    check("add2_psr", psr, 5'b00000);

    // NOT R6,R2: A=Rsrc, B=Rdest
    run_instr(16'h0672);
    check("not_a", cap_a, 16'h0004);
    check("not_b", cap_b, 16'h0007);
    check("not_r6", rf_mem[6], 16'hFFFB);

    // LSH R2,R3 (0x8 group)
    run_instr(16'h8243);
    check("lsh_op", cap_op, 8'h84);
    check("lsh_wdata", cap_wdata, 16'h0080);
    check("lsh_r2", rf_mem[2], 16'h0080);
    check("lsh_psr", psr, 5'b00000);

    // set psr non-zero, then reset in EXEC of ADD R1,R2
    run_instr(16'h5580);                  // R5 = 0 + 0xFF80, psr N=1
    check("addi2_psr", psr, 5'b10000);
    instr_valid = 1'b1; instr = 16'h0152;
    tick();
    instr_valid = 1'b0; instr = '0;
    tick();
    check("abort_in_exec", alu_op, 8'h05);
    #2 rst_n = 1'b0;
    #1;
    check("abort_we", rf_we, 0);
    check("abort_psr", psr, 0);
    check("abort_ready", instr_ready, 0);
    check("abort_alu_op", alu_op, 0);
    tick();
    check("abort_we_held", rf_we, 0);
    rst_n = 1'b1;
    #1 check("abort_ready_rel", instr_ready, 0);
    tick();
    check("abort_ready_edge", instr_ready, 1);
    tick();
    tick();
    check("abort_r1", rf_mem[1], 16'h0000);
    check("abort_done", done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
